// File: rtl/imem_fetch_rom_if.sv
// Fetch-side bus of imem_fetch_rom: request/response handshake, flush and program-load port.
// The master is the PC/fetch logic (or a bench); the slave is the instruction memory.
interface imem_fetch_rom_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_instr;
  logic [ADDR_W-1:0] resp_pc;
  logic [1:0]        resp_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [XLEN-1:0]   prog_data;

  modport master (
    output req_valid, req_pc, flush, resp_ready, prog_we, prog_addr, prog_data,
    input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );

  modport slave (
    input  req_valid, req_pc, flush, resp_ready, prog_we, prog_addr, prog_data,
    output req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );
endinterface

// File: rtl/imem_fetch_rom.sv
// imem_fetch_rom: parametrised instruction memory for the fetch stage.
// Valid/ready request/response with backpressure, flush, fault classification
// (01 misaligned, 10 out-of-range) and a program-load write port.
// Optional macro IMEM_FETCH_STATS_EN adds stat_fetch/stat_flushed/stat_fault counters.
module imem_fetch_rom #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 1024,
  parameter int unsigned     ADDR_W   = 32,
  parameter int unsigned     LATENCY  = 1,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013)
) (
  input logic             clk,
  input logic             rst_n,
  imem_fetch_rom_if.slave bus
`ifdef IMEM_FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetch,
  output logic [31:0]     stat_flushed,
  output logic [31:0]     stat_fault
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  if ((LATENCY != 1) && (LATENCY != 2)) begin : gen_bad_latency
    $error("imem_fetch_rom: LATENCY must be 1 or 2");
  end
  if ((DEPTH < 4) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("imem_fetch_rom: DEPTH must be a power of two in 4..65536");
  end

  // Fault code for a byte address; misalignment wins over out-of-range.
  function automatic logic [1:0] classify(input logic [ADDR_W-1:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if ((a >> 2) >= ADDR_W'(DEPTH)) return 2'b10;
    return 2'b00;
  endfunction

  // Power-up content is NOP; reset deliberately leaves the array alone.
  logic [XLEN-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic              resp_valid_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [1:0]        resp_fault_q;
  logic              resp_nop_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              advance;
  logic              accept;
  logic [1:0]        req_fault;
  logic [IdxW-1:0]   req_idx;

  logic              last_valid;
  logic [ADDR_W-1:0] last_pc;
  logic [1:0]        last_fault;
  logic [IdxW-1:0]   last_idx;
  logic              rd_en;
  logic              prog_ok;

`ifdef IMEM_FETCH_STATS_EN
  logic              s1_live;
`endif

  assign advance       = !resp_valid_q || bus.resp_ready;
  assign bus.req_ready = advance && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_fault     = classify(bus.req_pc);
  assign req_idx       = bus.req_pc[IdxW+1:2];

  if (LATENCY == 2) begin : gen_lat2
    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_pc_q;
    logic [1:0]        s1_fault_q;
    logic [IdxW-1:0]   s1_idx_q;

    // First stage: capture request metadata; the array is read on entry to the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_pc_q    <= '0;
        s1_fault_q <= 2'b00;
        s1_idx_q   <= '0;
      end else if (bus.flush) begin
        s1_valid_q <= 1'b0;
      end else if (advance) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_pc_q    <= bus.req_pc;
          s1_fault_q <= req_fault;
          s1_idx_q   <= req_idx;
        end
      end
    end

    assign last_valid = s1_valid_q;
    assign last_pc    = s1_pc_q;
    assign last_fault = s1_fault_q;
    assign last_idx   = s1_idx_q;
`ifdef IMEM_FETCH_STATS_EN
    assign s1_live    = s1_valid_q;
`endif
  end else begin : gen_lat1
    assign last_valid = accept;
    assign last_pc    = bus.req_pc;
    assign last_fault = req_fault;
    assign last_idx   = req_idx;
`ifdef IMEM_FETCH_STATS_EN
    assign s1_live    = 1'b0;
`endif
  end

  // Last stage control: flush beats hold, hold beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      resp_fault_q <= 2'b00;
      resp_nop_q   <= 1'b1;
    end else if (bus.flush) begin
      resp_valid_q <= 1'b0;
    end else if (advance) begin
      resp_valid_q <= last_valid;
      if (last_valid) begin
        resp_pc_q    <= last_pc;
        resp_fault_q <= last_fault;
        resp_nop_q   <= (last_fault != 2'b00);
      end
    end
  end

  assign rd_en = advance && !bus.flush && last_valid && (last_fault == 2'b00);

  // Synchronous read; non-blocking semantics give read-first against a same-edge write.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem[last_idx];
  end

  assign prog_ok = (classify(bus.prog_addr) == 2'b00);

  // Program load; misaligned or out-of-range addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (bus.prog_we && prog_ok) mem[bus.prog_addr[IdxW+1:2]] <= bus.prog_data;
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_pc    = resp_pc_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_instr = resp_nop_q ? NOP_WORD : rd_data_q;

`ifdef IMEM_FETCH_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] stat_fetch_q;
  logic [31:0] stat_flushed_q;
  logic [31:0] stat_fault_q;
  logic        resp_hs;
  logic [1:0]  flush_drop;

  assign resp_hs    = resp_valid_q && bus.resp_ready;
  assign flush_drop = {1'b0, resp_valid_q} + {1'b0, s1_live};

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetch_q   <= '0;
      stat_flushed_q <= '0;
      stat_fault_q   <= '0;
    end else begin
      if (resp_hs) stat_fetch_q <= sat_add(stat_fetch_q, 2'd1);
      if (resp_hs && (resp_fault_q != 2'b00)) stat_fault_q <= sat_add(stat_fault_q, 2'd1);
      if (bus.flush) stat_flushed_q <= sat_add(stat_flushed_q, flush_drop);
    end
  end

  assign stat_fetch   = stat_fetch_q;
  assign stat_flushed = stat_flushed_q;
  assign stat_fault   = stat_fault_q;
`endif

endmodule

// File: tb/tb_imem_fetch_rom.sv
// Bench for imem_fetch_rom: dut0 has LATENCY=1, dut1 has LATENCY=2.
// Stimulus pushes hand-computed expected responses; a monitor pops and compares on handshake.
module tb_imem_fetch_rom;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        rv  [2];
  logic [31:0] rpc [2];
  logic        fl  [2];
  logic        rr  [2];
  logic        pwe;
  logic [31:0] paddr;
  logic [31:0] pdata;

  logic        ordy   [2];
  logic        ovalid [2];
  logic [31:0] oinstr [2];
  logic [31:0] opc    [2];
  logic [1:0]  ofault [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks;
  int   errors;

  imem_fetch_rom_if #(.XLEN(32), .ADDR_W(32)) bus0 ();
  imem_fetch_rom_if #(.XLEN(32), .ADDR_W(32)) bus1 ();

  assign bus0.req_valid  = rv[0];
  assign bus0.req_pc     = rpc[0];
  assign bus0.flush      = fl[0];
  assign bus0.resp_ready = rr[0];
  assign bus0.prog_we    = pwe;
  assign bus0.prog_addr  = paddr;
  assign bus0.prog_data  = pdata;
  assign bus1.req_valid  = rv[1];
  assign bus1.req_pc     = rpc[1];
  assign bus1.flush      = fl[1];
  assign bus1.resp_ready = rr[1];
  assign bus1.prog_we    = pwe;
  assign bus1.prog_addr  = paddr;
  assign bus1.prog_data  = pdata;

  assign ordy[0]   = bus0.req_ready;
  assign ovalid[0] = bus0.resp_valid;
  assign oinstr[0] = bus0.resp_instr;
  assign opc[0]    = bus0.resp_pc;
  assign ofault[0] = bus0.resp_fault;
  assign ordy[1]   = bus1.req_ready;
  assign ovalid[1] = bus1.resp_valid;
  assign oinstr[1] = bus1.resp_instr;
  assign opc[1]    = bus1.resp_pc;
  assign ofault[1] = bus1.resp_fault;

`ifdef IMEM_FETCH_STATS_EN
  logic [31:0] st_fetch0, st_flushed0, st_fault0;
  logic [31:0] st_fetch1, st_flushed1, st_fault1;
`endif

  imem_fetch_rom #(.DEPTH(1024), .LATENCY(1)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
`ifdef IMEM_FETCH_STATS_EN
    ,
    .stat_fetch   (st_fetch0),
    .stat_flushed (st_flushed0),
    .stat_fault   (st_fault0)
`endif
  );

  imem_fetch_rom #(.DEPTH(1024), .LATENCY(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef IMEM_FETCH_STATS_EN
    ,
    .stat_fetch   (st_fetch1),
    .stat_flushed (st_flushed1),
    .stat_fault   (st_fault1)
`endif
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push(input int d, input logic [31:0] pc, input logic [31:0] ei,
                               input logic [1:0] ef);
    exp_t e;
    e = '{pc: pc, instr: ei, fault: ef};
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Monitor: compare every response handshake against the head of that DUT's queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && ovalid[d] && rr[d]) begin
        if (qsize(d) == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected response: got pc %h, expected none", d, opc[d]);
        end else begin
          exp_t e;
          if (d == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check($sformatf("dut%0d resp_pc", d), opc[d], e.pc);
          check($sformatf("dut%0d resp_instr pc=%h", d, e.pc), oinstr[d], e.instr);
          check($sformatf("dut%0d resp_fault pc=%h", d, e.pc), {30'd0, ofault[d]}, {30'd0, e.fault});
        end
      end
    end
  end

  // One cycle of stimulus; inputs change 2 time units after the edge, acceptance seen at negedge.
  task automatic drive(input int d, input logic v, input logic [31:0] pc, input logic f,
                       input logic r, input logic [31:0] ei, input logic [1:0] ef,
                       output logic acc);
    @(posedge clk);
    #2;
    rv[d] = v; rpc[d] = pc; fl[d] = f; rr[d] = r;
    @(negedge clk);
    acc = v && ordy[d];
    if (acc) push(d, pc, ei, ef);
  endtask

  task automatic idle(input int d, input logic r);
    logic acc;
    drive(d, 1'b0, 32'd0, 1'b0, r, 32'd0, 2'b00, acc);
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] dat);
    @(posedge clk);
    #2;
    pwe = 1'b1; paddr = a; pdata = dat;
    @(posedge clk);
    #2;
    pwe = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 50) begin
      idle(d, 1'b1);
      n++;
    end
    idle(d, 1'b1);
    idle(d, 1'b1);
    check($sformatf("dut%0d drain queue empty", d), qsize(d), 0);
  endtask

  logic [31:0] t2_pc    [4];
  logic [31:0] t2_instr [4];
  logic [6:0]  t2_pat;

  initial begin
    logic acc;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    pwe = 1'b0; paddr = '0; pdata = '0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rpc[d] = '0; fl[d] = 1'b0; rr[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset resp_valid", d), {31'd0, ovalid[d]}, 0);
      check($sformatf("dut%0d reset resp_instr", d), oinstr[d], NOP);
      check($sformatf("dut%0d reset resp_pc", d), opc[d], 0);
      check($sformatf("dut%0d reset resp_fault", d), {30'd0, ofault[d]}, 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("dut0 idle req_ready", {31'd0, ordy[0]}, 1);
    check("dut1 idle req_ready", {31'd0, ordy[1]}, 1);

    // Program load, including a misaligned and an out-of-range write that must be dropped.
    prog(32'h0000_0000, 32'h0010_0093);
    prog(32'h0000_0004, 32'h0020_0113);
    prog(32'h0000_0008, 32'h0050_0093);
    prog(32'h0000_000C, 32'h0030_0193);
    prog(32'h0000_0020, 32'h0200_0213);
    prog(32'h0000_0012, 32'hDEAD_BEEF);
    prog(32'h0000_1000, 32'hBADB_AD00);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // LATENCY=1 single fetch.
    drive(0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0050_0093, 2'b00, acc);
    check("t1 accepted", {31'd0, acc}, 1);
    check("t1 resp_valid before edge", {31'd0, ovalid[0]}, 0);
    idle(0, 1'b1);
    check("t1 resp_valid next cycle", {31'd0, ovalid[0]}, 1);
    idle(0, 1'b1);
    check("t1 single response", {31'd0, ovalid[0]}, 0);

    // LATENCY=2 back-to-back stream, no gaps.
    t2_pc    = '{32'h0, 32'h4, 32'h8, 32'hC};
    t2_instr = '{32'h0010_0093, 32'h0020_0113, 32'h0050_0093, 32'h0030_0193};
    t2_pat   = 7'b0111100;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        drive(1, 1'b1, t2_pc[k], 1'b0, 1'b1, t2_instr[k], 2'b00, acc);
        check($sformatf("t2 accept %0d", k), {31'd0, acc}, 1);
      end else begin
        idle(1, 1'b1);
      end
      check($sformatf("t2 resp_valid cycle %0d", k), {31'd0, ovalid[1]}, {31'd0, t2_pat[k]});
    end
    drain(1);

    // Fault classification and dropped program writes.
    drive(0, 1'b1, 32'h0000_0006, 1'b0, 1'b1, NOP, 2'b01, acc);
    drive(0, 1'b1, 32'h0000_1000, 1'b0, 1'b1, NOP, 2'b10, acc);
    drive(0, 1'b1, 32'h0000_1002, 1'b0, 1'b1, NOP, 2'b01, acc);
    drive(0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, NOP, 2'b00, acc);
    drive(0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0010_0093, 2'b00, acc);
    drain(0);
`ifdef IMEM_FETCH_STATS_EN
    check("t3 stat_fault", st_fault0, 3);
    check("t3 stat_fetch", st_fetch0, 6);
`endif

    // Backpressure: hold for 5 cycles, then drain in order.
    drive(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0010_0093, 2'b00, acc);
    check("t4 first accept", {31'd0, acc}, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0020_0113, 2'b00, acc);
      check($sformatf("t4 req_ready low %0d", k), {31'd0, acc}, 0);
      check($sformatf("t4 held valid %0d", k), {31'd0, ovalid[0]}, 1);
      check($sformatf("t4 held pc %0d", k), opc[0], 32'h0);
      check($sformatf("t4 held instr %0d", k), oinstr[0], 32'h0010_0093);
      check($sformatf("t4 held fault %0d", k), {30'd0, ofault[0]}, 0);
    end
    drive(0, 1'b1, 32'h4, 1'b0, 1'b1, 32'h0020_0113, 2'b00, acc);
    check("t4 accept on release", {31'd0, acc}, 1);
    drive(0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0050_0093, 2'b00, acc);
    drive(0, 1'b1, 32'hC, 1'b0, 1'b1, 32'h0030_0193, 2'b00, acc);
    drain(0);

    // Flush with two entries in flight on LATENCY=2.
    drive(1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0010_0093, 2'b00, acc);
    check("t5 accept a", {31'd0, acc}, 1);
    drive(1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0020_0113, 2'b00, acc);
    check("t5 accept b", {31'd0, acc}, 1);
    drive(1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0050_0093, 2'b00, acc);
    check("t5 req_ready in flush", {31'd0, acc}, 0);
    q1.delete();
    drive(1, 1'b1, 32'h20, 1'b0, 1'b1, 32'h0200_0213, 2'b00, acc);
    check("t5 accept after flush", {31'd0, acc}, 1);
    check("t5 resp_valid after flush", {31'd0, ovalid[1]}, 0);
`ifdef IMEM_FETCH_STATS_EN
    check("t5 stat_flushed", st_flushed1, 2);
`endif
    drain(1);

    // Asynchronous reset mid-stream; array survives.
    drive(0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0010_0093, 2'b00, acc);
    drive(0, 1'b1, 32'h4, 1'b0, 1'b1, 32'h0020_0113, 2'b00, acc);
    drive(0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0050_0093, 2'b00, acc);
    check("t6 valid before reset", {31'd0, ovalid[0]}, 1);
    #1 rst_n = 1'b0;
    rv[0] = 1'b0;
    #1;
    check("t6 resp_valid on reset", {31'd0, ovalid[0]}, 0);
    check("t6 resp_instr on reset", oinstr[0], NOP);
    check("t6 resp_pc on reset", opc[0], 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0050_0093, 2'b00, acc);
    check("t6 accept after reset", {31'd0, acc}, 1);
    drain(0);
    drive(1, 1'b1, 32'h20, 1'b0, 1'b1, 32'h0200_0213, 2'b00, acc);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
